pulse_width_capture: RTL and testbench
======================================

Name: pulse_width_capture

Overview:
Multi-channel successor to the single-channel run-length capture block. Each channel compares a Q_WIDTH-bit status input against a programmable pattern and mask, and counts consecutive matching cycles. When a run ends, it records {channel, length, saturated} and queues it in an output FIFO, which is drained over a valid/ready interface. Sits between the sampled status buses and the readout/UART path.

Parameters:
NUM_CH, 2, number of independent input channels (1..16)
Q_WIDTH, 4, bits per channel status input
CNT_WIDTH, 8, run-length counter and result width
FIFO_DEPTH, 4, output queue entries (power of 2, >=2)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  capture enable
pattern  in  Q_WIDTH  match pattern, shared by all channels
mask  in  Q_WIDTH  1 = bit participates in the compare
min_len  in  CNT_WIDTH  runs with length < min_len are discarded
q  in  NUM_CH*Q_WIDTH  status inputs, channel c = q[c*Q_WIDTH +: Q_WIDTH]
active  out  NUM_CH  registered per-channel "run in progress" flag
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts head
out_ch  out  CH_W  channel of head entry, CH_W = max(1, clog2(NUM_CH))
out_len  out  CNT_WIDTH  run length of head entry
out_sat  out  1  head run length saturated
fifo_level  out  clog2(FIFO_DEPTH)+1  entries held
overflow  out  1  sticky: a completed run was dropped
clr_ovf  in  1  single-cycle clear for overflow

Behaviour:
- Reset (async on rst_n low, released synchronously by design): all counters 0, active=0, pending=0, FIFO empty, out_valid=0, out_ch/out_len/out_sat=0, fifo_level=0, overflow=0, RR pointer=0.
- match[c] = ((q_c & mask) == (pattern & mask)). mask=0 means every cycle matches.
- Per channel, each edge with en=1:
  - If match: cnt <= cnt+1, saturating at 2^CNT_WIDTH-1; sat flag set when saturation is reached. active <= 1.
  - If not match and cnt!=0: the run ends. cnt <= 0, sat <= 0, active <= 0. If cnt >= min_len (min_len=0 or 1 keeps every run), load pending[c] = {cnt, sat}. If pending[c] is already occupied and is not granted this same cycle, drop the result and set overflow.
  - If not match and cnt==0: no action.
- en=0: counters, sat and active are cleared and in-progress runs are aborted with no capture. Pending registers and the FIFO keep running, so draining continues.
- Arbiter: one FIFO write per cycle. Round-robin among occupied pending registers, starting at the channel after the last grant. A grant occurs only when the FIFO is not full, and it clears pending[c].
- Same-cycle release and reload of pending[c] is allowed; the new run is stored.
- FIFO: push on grant, pop on out_valid & out_ready. Simultaneous push and pop when full is not permitted, because a grant requires not-full. Simultaneous push and pop otherwise leaves the level unchanged.
- out_valid = (fifo_level != 0). Head fields are stable while out_valid=1 and out_ready=0.
- Latency: the first non-matching sample is seen at edge N. pending is set after N, the FIFO write happens at N+1, and out_valid goes high after N+1 when the FIFO was empty.
- overflow: set on any drop. clr_ovf clears it. If a set and a clear occur in the same cycle, the set wins.
- Reset mid-run or mid-drain discards everything with no partial outputs.

Decomposition:
- Package pwc_pkg holds:
  - the CH_W function
  - the entry struct {ch, len, sat}
  - the width constants
- Sub-module pwc_fifo: a synchronous FIFO parametrised by width and depth, with its own level counter and full/empty flags, using the same clk and rst_n.
- Channel counters and the arbiter are generate loops in the top level.

Test Plan:
1. NUM_CH=2, mask=4'hF, pattern=4'hF, min_len=0; ch0 matches for 5 cycles -> one entry {ch=0,len=5,sat=0}; out_valid rises 2 cycles after the first non-match sample.
2. Ch1 matches for 300 cycles with CNT_WIDTH=8 -> {ch=1,len=255,sat=1}; active[1]=1 throughout the run.
3. min_len=3; ch0 runs of length 2, then length 3 -> only the length-3 entry appears.
4. Ch0 and ch1 runs end on the same edge, twice -> 4 entries. The order is ch0,ch1 then ch1,ch0 (round-robin rotation).
5. out_ready=0, FIFO_DEPTH=4; ch0 produces 6 runs of length 2 separated by 1-cycle gaps -> fifo_level=4 and pending holds the 5th. The 6th is dropped and overflow=1. clr_ovf clears overflow. Draining then yields 5 entries.
6. Deassert rst_n during a ch0 run and with 2 FIFO entries queued -> all outputs return to 0 immediately. After release, with q held at a non-match value, no entries appear.

Source files
------------

// File: rtl/pwc_pkg.sv
// Shared constants, width helper and result entry type for the pulse-width capture block.
package pwc_pkg;

  localparam int DEF_NUM_CH     = 2;
  localparam int DEF_Q_WIDTH    = 4;
  localparam int DEF_CNT_WIDTH  = 8;
  localparam int DEF_FIFO_DEPTH = 4;

  // Channel-index width; a single channel still needs one bit on the output port.
  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  localparam int DEF_CH_W = ch_width(DEF_NUM_CH);

  typedef struct packed {
    logic [DEF_CH_W-1:0]      ch;
    logic [DEF_CNT_WIDTH-1:0] len;
    logic                     sat;
  } entry_t;

endpackage

// File: rtl/pwc_fifo.sv
// Synchronous FIFO with level counter; head reads as zero whenever the queue is empty.
module pwc_fifo
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: the storage array is deliberately not reset; empty gates the head so stale words never leak out.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/pulse_width_capture.sv
// Multi-channel run-length capture: per-channel match counters, one pending slot per channel,
// a round-robin arbiter into a shared output FIFO, and a sticky overflow flag.
module pulse_width_capture
  import pwc_pkg::*;
#(
  parameter  int NUM_CH     = DEF_NUM_CH,
  parameter  int Q_WIDTH    = DEF_Q_WIDTH,
  parameter  int CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter  int FIFO_DEPTH = DEF_FIFO_DEPTH,
  localparam int CH_W       = ch_width(NUM_CH),
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [Q_WIDTH-1:0]        pattern,
  input  logic [Q_WIDTH-1:0]        mask,
  input  logic [CNT_WIDTH-1:0]      min_len,
  input  logic [NUM_CH*Q_WIDTH-1:0] q,
  output logic [NUM_CH-1:0]         active,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CH_W-1:0]           out_ch,
  output logic [CNT_WIDTH-1:0]      out_len,
  output logic                      out_sat,
  output logic [LVL_W-1:0]          fifo_level,
  output logic                      overflow,
  input  logic                      clr_ovf
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam int                   ENTRY_W = CH_W + CNT_WIDTH + 1;

  logic [NUM_CH-1:0]              pend_valid;
  logic [NUM_CH-1:0]              grant;
  logic [NUM_CH-1:0]              drop;
  logic [NUM_CH-1:0][CNT_WIDTH:0] pend_word;

  logic                 grant_any;
  logic [CH_W-1:0]      grant_ch;
  logic [CNT_WIDTH:0]   grant_word;
  logic [CH_W-1:0]      rr_ptr;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [ENTRY_W-1:0]   push_data;
  logic [ENTRY_W-1:0]   head_data;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CNT_WIDTH-1:0] cnt;
    logic                 sat;
    logic                 active_r;
    logic                 pend_v;
    logic [CNT_WIDTH-1:0] pend_len;
    logic                 pend_sat;
    logic                 match;
    logic                 keep;

    assign match    = ((q[c*Q_WIDTH +: Q_WIDTH] & mask) == (pattern & mask));
    assign keep     = en && !match && (cnt != '0) && (cnt >= min_len);
    assign grant[c] = grant_any && (grant_ch == CH_W'(c));
    // A finished run is lost only if the slot stays occupied through this edge.
    assign drop[c]  = keep && pend_v && !grant[c];

    // NOTE: sequential state uses <= so every register sees the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt      <= '0;
        sat      <= 1'b0;
        active_r <= 1'b0;
      end else if (!en || !match) begin
        cnt      <= '0;
        sat      <= 1'b0;
        active_r <= 1'b0;
      end else begin
        active_r <= 1'b1;
        if (cnt != CNT_MAX) begin
          cnt <= cnt + 1'b1;
          sat <= (cnt == CNT_MAX - 1'b1);
        end else begin
          sat <= 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pend_v   <= 1'b0;
        pend_len <= '0;
        pend_sat <= 1'b0;
      end else if (keep && (!pend_v || grant[c])) begin
        pend_v   <= 1'b1;
        pend_len <= cnt;
        pend_sat <= sat;
      end else if (grant[c]) begin
        pend_v   <= 1'b0;
      end
    end

    assign active[c]     = active_r;
    assign pend_valid[c] = pend_v;
    assign pend_word[c]  = {pend_len, pend_sat};
  end

  // Round-robin search starting at rr_ptr, which always points one past the last grant.
  always_comb begin
    int              sum;
    logic [CH_W-1:0] idx;
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    grant_any  = 1'b0;
    grant_ch   = '0;
    grant_word = '0;
    sum        = 0;
    idx        = '0;
    for (int off = 0; off < NUM_CH; off++) begin
      sum = int'(rr_ptr) + off;
      if (sum >= NUM_CH) sum = sum - NUM_CH;
      idx = CH_W'(sum);
      if (!grant_any && pend_valid[idx]) begin
        grant_any  = 1'b1;
        grant_ch   = idx;
        grant_word = pend_word[idx];
      end
    end
    if (fifo_full) grant_any = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      rr_ptr <= (grant_ch == CH_W'(NUM_CH - 1)) ? '0 : grant_ch + 1'b1;
    end
  end

  // Set has priority over clear so a drop in the clearing cycle is never hidden.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (|drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  assign push_data = {grant_ch, grant_word};

  pwc_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (grant_any),
    .push_data (push_data),
    .pop       (out_valid && out_ready),
    .pop_data  (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign out_valid                  = !fifo_empty;
  assign {out_ch, out_len, out_sat} = head_data;

endmodule

// File: tb/tb_pulse_width_capture.sv
// Directed bench for pulse_width_capture: latency, saturation, min_len filter, enable abort,
// round-robin order, overflow handling and mid-run reset, all with hand-computed expectations.
module tb_pulse_width_capture;
  import pwc_pkg::*;

  localparam int NUM_CH     = 2;
  localparam int Q_WIDTH    = 4;
  localparam int CNT_WIDTH  = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int CH_W       = 1;
  localparam int LVL_W      = 3;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      en = 1'b0;
  logic [Q_WIDTH-1:0]        pattern = '0;
  logic [Q_WIDTH-1:0]        mask = '0;
  logic [CNT_WIDTH-1:0]      min_len = '0;
  logic [NUM_CH*Q_WIDTH-1:0] q = '0;
  logic [NUM_CH-1:0]         active;
  logic                      out_valid;
  logic                      out_ready = 1'b0;
  logic [CH_W-1:0]           out_ch;
  logic [CNT_WIDTH-1:0]      out_len;
  logic                      out_sat;
  logic [LVL_W-1:0]          fifo_level;
  logic                      overflow;
  logic                      clr_ovf = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pulse_width_capture #(
    .NUM_CH     (NUM_CH),
    .Q_WIDTH    (Q_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .pattern    (pattern),
    .mask       (mask),
    .min_len    (min_len),
    .q          (q),
    .active     (active),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ch     (out_ch),
    .out_len    (out_len),
    .out_sat    (out_sat),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_q(input logic [3:0] q0, input logic [3:0] q1);
    q = {q1, q0};
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Waits (bounded) for a head entry, checks it, then pops it with a one-cycle ready pulse.
  task automatic expect_pop(input string tag, input entry_t exp);
    int waited;
    waited = 0;
    while (!out_valid && waited < 20) begin
      tick();
      waited++;
    end
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".ch"},    32'(out_ch),    32'(exp.ch));
    check({tag, ".len"},   32'(out_len),   32'(exp.len));
    check({tag, ".sat"},   32'(out_sat),   32'(exp.sat));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // One ch0 run of length 2 followed by a single non-matching cycle.
  task automatic ch0_short_run();
    set_q(4'hF, 4'h0);
    ticks(2);
    set_q(4'h0, 4'h0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    pattern = 4'hF;
    mask    = 4'hF;
    min_len = 8'd0;
    en      = 1'b1;
    set_q(4'h0, 4'h0);
    ticks(2);
    check("rst.valid",    32'(out_valid),  32'd0);
    check("rst.level",    32'(fifo_level), 32'd0);
    check("rst.active",   32'(active),     32'd0);
    check("rst.overflow", 32'(overflow),   32'd0);
    check("rst.len",      32'(out_len),    32'd0);
    rst_n = 1'b1;
    tick();

    // Single run of 5 on ch0; valid rises two edges after the first non-match.
    set_q(4'hF, 4'h0);
    ticks(5);
    check("t1.active", 32'(active), 32'b01);
    set_q(4'h0, 4'h0);
    tick();
    check("t1.valid_n", 32'(out_valid), 32'd0);
    check("t1.active_end", 32'(active), 32'b00);
    tick();
    check("t1.valid_n1", 32'(out_valid), 32'd1);
    check("t1.level", 32'(fifo_level), 32'd1);
    expect_pop("t1", entry_t'{ch: 1'b0, len: 8'd5, sat: 1'b0});
    check("t1.level_after", 32'(fifo_level), 32'd0);

    // min_len=3: the length-2 run is discarded, the length-3 run kept.
    min_len = 8'd3;
    ch0_short_run();
    ticks(2);
    check("t3.discard", 32'(fifo_level), 32'd0);
    set_q(4'hF, 4'h0);
    ticks(3);
    set_q(4'h0, 4'h0);
    ticks(2);
    check("t3.level", 32'(fifo_level), 32'd1);
    expect_pop("t3", entry_t'{ch: 1'b0, len: 8'd3, sat: 1'b0});
    min_len = 8'd0;

    // Dropping en aborts the run in progress without capture.
    set_q(4'hF, 4'h0);
    ticks(3);
    check("en.active", 32'(active), 32'b01);
    en = 1'b0;
    tick();
    check("en.abort", 32'(active), 32'b00);
    en = 1'b1;
    set_q(4'h0, 4'h0);
    ticks(3);
    check("en.no_entry", 32'(fifo_level), 32'd0);

    // 300-cycle ch1 run saturates at 255.
    set_q(4'h0, 4'hF);
    for (int i = 0; i < 300; i++) begin
      tick();
      check("t2.active", 32'(active[1]), 32'd1);
    end
    set_q(4'h0, 4'h0);
    tick();
    expect_pop("t2", entry_t'{ch: 1'b1, len: 8'd255, sat: 1'b1});

    // Last grant was ch1, so the first simultaneous pair drains ch0 then ch1.
    set_q(4'hF, 4'h0);
    tick();
    set_q(4'hF, 4'hF);
    ticks(2);
    set_q(4'h0, 4'h0);
    tick();
    expect_pop("t4.a0", entry_t'{ch: 1'b0, len: 8'd3, sat: 1'b0});
    expect_pop("t4.a1", entry_t'{ch: 1'b1, len: 8'd2, sat: 1'b0});
    // A lone ch0 run moves the pointer past ch0, so the second pair drains ch1 first.
    set_q(4'hF, 4'h0);
    tick();
    set_q(4'h0, 4'h0);
    tick();
    expect_pop("t4.lone", entry_t'{ch: 1'b0, len: 8'd1, sat: 1'b0});
    set_q(4'h0, 4'hF);
    tick();
    set_q(4'hF, 4'hF);
    ticks(4);
    set_q(4'h0, 4'h0);
    tick();
    expect_pop("t4.b1", entry_t'{ch: 1'b1, len: 8'd5, sat: 1'b0});
    expect_pop("t4.b0", entry_t'{ch: 1'b0, len: 8'd4, sat: 1'b0});

    // Six runs with no consumer: four queued, one pending, one dropped.
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) ch0_short_run();
    check("t5.level", 32'(fifo_level), 32'd4);
    check("t5.ovf", 32'(overflow), 32'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("t5.ovf_clr", 32'(overflow), 32'd0);
    for (int k = 0; k < 5; k++) expect_pop($sformatf("t5.d%0d", k), entry_t'{ch: 1'b0, len: 8'd2, sat: 1'b0});
    ticks(2);
    check("t5.empty", 32'(fifo_level), 32'd0);
    check("t5.valid", 32'(out_valid), 32'd0);

    // Reset mid-run with two entries queued.
    ch0_short_run();
    ch0_short_run();
    tick();
    check("t6.level", 32'(fifo_level), 32'd2);
    set_q(4'hF, 4'h0);
    ticks(3);
    check("t6.active", 32'(active), 32'b01);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6.rst_valid",  32'(out_valid),  32'd0);
    check("t6.rst_level",  32'(fifo_level), 32'd0);
    check("t6.rst_active", 32'(active),     32'd0);
    check("t6.rst_ch",     32'(out_ch),     32'd0);
    check("t6.rst_len",    32'(out_len),    32'd0);
    check("t6.rst_sat",    32'(out_sat),    32'd0);
    set_q(4'h0, 4'h0);
    tick();
    rst_n = 1'b1;
    ticks(5);
    check("t6.post_level", 32'(fifo_level), 32'd0);
    check("t6.post_valid", 32'(out_valid),  32'd0);
    check("t6.post_ovf",   32'(overflow),   32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
